// File: rtl/game_step_scheduler.sv
// game_step_scheduler: frame-paced sequencer for the game-logic block and the
// LED-matrix display driver. It divides the clock down to a frame tick,
// latches button presses between steps, runs one e_act handshake per frame,
// grants the display phase and supervises both handshakes with a watchdog.
//
// state | meaning
// ------+--------------------------------------------------------------
// INIT  | hold game_reset_o for RST_CYC cycles after reset release
// WAIT  | idle, waiting for the next frame tick
// STEP  | e_act_o high with latched up/down, waiting for d_act_i
// DISP  | disp_en_o high, waiting for disp_done_i
module game_step_scheduler #(
  parameter int                DIV_W     = 16,
  parameter logic [DIV_W-1:0]  FRAME_DIV = 16'd50000,
  parameter int                TO_W      = 8,
  parameter logic [TO_W-1:0]   TIMEOUT   = 8'd200,
  parameter int                RST_CYC   = 4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        up_btn_i,
  input  logic        down_btn_i,
  input  logic        d_act_i,
  input  logic        disp_done_i,
  output logic        game_reset_o,
  output logic        e_act_o,
  output logic        up_o,
  output logic        down_o,
  output logic        disp_en_o,
  output logic [15:0] step_cnt_o,
  output logic        overrun_o,
  output logic        timeout_o
);

  localparam int RC_W = $clog2(RST_CYC + 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_WAIT = 2'd1,
    S_STEP = 2'd2,
    S_DISP = 2'd3
  } state_t;

  state_t           state;
  logic [RC_W-1:0]  rst_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [TO_W-1:0]  wd_cnt;
  logic             tick;
  logic             load;
  logic             up_s1, up_s2, up_s3;
  logic             dn_s1, dn_s2, dn_s3;
  logic             up_rise, dn_rise;
  logic             pend_up, pend_dn;

  assign tick    = (state != S_INIT) && (div_cnt == FRAME_DIV - DIV_W'(1));
  assign load    = (state == S_WAIT) && tick;
  assign up_rise = up_s2 & ~up_s3;
  assign dn_rise = dn_s2 & ~dn_s3;

  // Frame prescaler: free-runs outside INIT, wraps on the tick.
  always_ff @(posedge clk_i) begin
    if (!reset_ni || state == S_INIT) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Button synchronisers plus a third flop for rising-edge detection.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      {up_s1, up_s2, up_s3} <= 3'b000;
      {dn_s1, dn_s2, dn_s3} <= 3'b000;
    end else begin
      {up_s1, up_s2, up_s3} <= {up_btn_i, up_s1, up_s2};
      {dn_s1, dn_s2, dn_s3} <= {down_btn_i, dn_s1, dn_s2};
    end
  end

  // Pending presses: a new edge wins over the clear at step load.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      pend_up <= 1'b0;
      pend_dn <= 1'b0;
    end else begin
      if (up_rise)   pend_up <= 1'b1;
      else if (load) pend_up <= 1'b0;
      if (dn_rise)   pend_dn <= 1'b1;
      else if (load) pend_dn <= 1'b0;
    end
  end

  // Scheduler FSM with registered outputs, watchdog and sticky flags.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state        <= S_INIT;
      rst_cnt      <= '0;
      wd_cnt       <= '0;
      game_reset_o <= 1'b1;
      e_act_o      <= 1'b0;
      up_o         <= 1'b0;
      down_o       <= 1'b0;
      disp_en_o    <= 1'b0;
      step_cnt_o   <= '0;
      overrun_o    <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      // A tick during a busy phase is flagged and dropped, never queued.
      if (tick && (state == S_STEP || state == S_DISP)) overrun_o <= 1'b1;
      case (state)
        S_INIT: begin
          if (rst_cnt == RC_W'(RST_CYC)) begin
            game_reset_o <= 1'b0;
            state        <= S_WAIT;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        S_WAIT: begin
          if (tick) begin
            e_act_o <= 1'b1;
            // Simultaneous up and down presses cancel each other.
            up_o    <= pend_up & ~pend_dn;
            down_o  <= pend_dn & ~pend_up;
            wd_cnt  <= '0;
            state   <= S_STEP;
          end
        end
        S_STEP: begin
          if (d_act_i) begin
            e_act_o    <= 1'b0;
            up_o       <= 1'b0;
            down_o     <= 1'b0;
            step_cnt_o <= step_cnt_o + 16'd1;
            disp_en_o  <= 1'b1;
            wd_cnt     <= '0;
            state      <= S_DISP;
          end else if (wd_cnt == TIMEOUT - TO_W'(1)) begin
            timeout_o <= 1'b1;
            e_act_o   <= 1'b0;
            up_o      <= 1'b0;
            down_o    <= 1'b0;
            state     <= S_WAIT;
          end else begin
            wd_cnt <= wd_cnt + TO_W'(1);
          end
        end
        S_DISP: begin
          if (disp_done_i) begin
            disp_en_o <= 1'b0;
            state     <= S_WAIT;
          end else if (wd_cnt == TIMEOUT - TO_W'(1)) begin
            timeout_o <= 1'b1;
            disp_en_o <= 1'b0;
            state     <= S_WAIT;
          end else begin
            wd_cnt <= wd_cnt + TO_W'(1);
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
